// File: rtl/reset_sequencer_if.sv
// Board-side signal bundle of the reset sequencer: PLL/external reset inputs,
// synchronised inputs, per-domain resets and the reset-cause register.
interface reset_sequencer_if #(
  parameter int unsigned SYNC_W = 1,
  parameter int unsigned STAGES = 2
);
  logic                pll_locked;
  logic                ext_reset;
  logic [SYNC_W-1:0]   sync_in;
  logic [SYNC_W-1:0]   sync_out;
  logic [STAGES-1:0]   stage_reset_n;
  logic                all_released;
  logic [2:0]          reset_cause;
  logic                cause_clear;

  modport master (
    output pll_locked, ext_reset, sync_in, cause_clear,
    input  sync_out, stage_reset_n, all_released, reset_cause
  );

  modport slave (
    input  pll_locked, ext_reset, sync_in, cause_clear,
    output sync_out, stage_reset_n, all_released, reset_cause
  );
endinterface

// File: rtl/reset_sequencer.sv
// Core-domain reset generator: PLL lock filter, external reset synchroniser,
// staggered per-domain reset release, input synchronisers and sticky reset cause.
module reset_sequencer #(
  parameter int unsigned       LOCK_FILTER     = 4,
  parameter int unsigned       RELEASE_DELAY   = 255,
  parameter int unsigned       STAGES          = 2,
  parameter int unsigned       STAGE_GAP       = 16,
  parameter bit                EXT_ACTIVE_HIGH = 1'b1,
  parameter int unsigned       SYNC_W          = 1,
  parameter int unsigned       SYNC_DEPTH      = 2,
  parameter logic [SYNC_W-1:0] SYNC_IDLE       = '1
) (
  input  logic               clk_core,
  input  logic               core_reset_n,
  reset_sequencer_if.slave   bus
);

  localparam int unsigned TMAX = RELEASE_DELAY + (STAGES - 1) * STAGE_GAP;
  localparam int unsigned CW   = (TMAX == 0) ? 1 : $clog2(TMAX + 1);

  logic [LOCK_FILTER-1:0] window_q;
  logic                   pll_stable_q;
  logic                   ext_meta_q;
  logic                   ext_sync_q;
  logic [CW-1:0]          count_q;
  logic [STAGES-1:0]      stage_q;
  logic                   all_q;
  logic [2:0]             cause_q;
  logic [SYNC_W-1:0]      chain_q [SYNC_DEPTH];

  logic                   ext_asserted;
  logic                   hold;
  logic [2:0]             cause_set;

  assign ext_asserted = EXT_ACTIVE_HIGH ? bus.ext_reset : ~bus.ext_reset;
  assign hold         = ~pll_stable_q | ext_sync_q;
  // Events are detected on the edge where the registered flag changes.
  assign cause_set    = {ext_meta_q & ~ext_sync_q, pll_stable_q & ~(&window_q), 1'b0};

  // Lock filter and external reset synchroniser
  always_ff @(posedge clk_core) begin
    if (!core_reset_n) begin
      window_q     <= '0;
      pll_stable_q <= 1'b0;
      ext_meta_q   <= 1'b1;
      ext_sync_q   <= 1'b1;
    end else begin
      window_q     <= LOCK_FILTER'({window_q, bus.pll_locked});
      pll_stable_q <= &window_q;
      ext_meta_q   <= ext_asserted;
      ext_sync_q   <= ext_meta_q;
    end
  end

  // Saturating release counter and staggered stage release
  always_ff @(posedge clk_core) begin
    if (!core_reset_n) begin
      count_q <= '0;
      stage_q <= '0;
      all_q   <= 1'b0;
    end else begin
      if (hold) begin
        count_q <= '0;
      end else if (count_q != CW'(TMAX)) begin
        count_q <= count_q + CW'(1);
      end
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= ~hold & (count_q >= CW'(RELEASE_DELAY + i * STAGE_GAP));
      end
      // The last stage has the largest threshold, so it alone decides all_released.
      all_q <= ~hold & (count_q >= CW'(TMAX));
    end
  end

  // Input synchronisers, forced idle while stage 0 is in reset
  always_ff @(posedge clk_core) begin
    if (!core_reset_n || !stage_q[0]) begin
      for (int unsigned d = 0; d < SYNC_DEPTH; d++) begin
        chain_q[d] <= SYNC_IDLE;
      end
    end else begin
      chain_q[0] <= bus.sync_in;
      for (int unsigned d = 1; d < SYNC_DEPTH; d++) begin
        chain_q[d] <= chain_q[d-1];
      end
    end
  end

  // Sticky reset cause; a set event beats a simultaneous clear
  always_ff @(posedge clk_core) begin
    if (!core_reset_n) begin
      cause_q <= 3'b001;
    end else begin
      cause_q <= (bus.cause_clear ? 3'b000 : cause_q) | cause_set;
    end
  end

  assign bus.sync_out      = chain_q[SYNC_DEPTH-1];
  assign bus.stage_reset_n = stage_q;
  assign bus.all_released  = all_q;
  assign bus.reset_cause   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: one active-high and one active-low external
// reset instance driven with equivalent stimulus and checked against one table.
module tb_reset_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  reset_sequencer_if #(.SYNC_W(1), .STAGES(3)) bus_h ();
  reset_sequencer_if #(.SYNC_W(1), .STAGES(3)) bus_l ();

  reset_sequencer #(
    .LOCK_FILTER(4), .RELEASE_DELAY(8), .STAGES(3), .STAGE_GAP(4),
    .EXT_ACTIVE_HIGH(1'b1), .SYNC_W(1), .SYNC_DEPTH(2), .SYNC_IDLE(1'b1)
  ) dut_h (
    .clk_core     (clk),
    .core_reset_n (rst_n),
    .bus          (bus_h)
  );

  reset_sequencer #(
    .LOCK_FILTER(4), .RELEASE_DELAY(8), .STAGES(3), .STAGE_GAP(4),
    .EXT_ACTIVE_HIGH(1'b0), .SYNC_W(1), .SYNC_DEPTH(2), .SYNC_IDLE(1'b1)
  ) dut_l (
    .clk_core     (clk),
    .core_reset_n (rst_n),
    .bus          (bus_l)
  );

  typedef struct {
    int unsigned n;
    logic        rst;
    logic        lock;
    logic        ext;
    logic        sin;
    logic [2:0]  stg;
    logic        all;
    logic [2:0]  cause;
    logic        so;
  } vec_t;

  vec_t tbl[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   row_no     = 0;

  task automatic add(input int unsigned n, input logic rst, input logic lock,
                     input logic ext, input logic sin, input logic [2:0] stg,
                     input logic all, input logic [2:0] cause, input logic so);
    vec_t v;
    v.n = n; v.rst = rst; v.lock = lock; v.ext = ext; v.sin = sin;
    v.stg = stg; v.all = all; v.cause = cause; v.so = so;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic lock, input logic ext,
                       input logic sin, input logic clr);
    rst_n            = rst;
    bus_h.pll_locked = lock;  bus_l.pll_locked = lock;
    bus_h.ext_reset  = ext;   bus_l.ext_reset  = ~ext;
    bus_h.sync_in    = sin;   bus_l.sync_in    = sin;
    bus_h.cause_clear = clr;  bus_l.cause_clear = clr;
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input string fld,
                     input logic [2:0] got, input logic [2:0] exp);
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s %s: got %b expected %b", name, fld, got, exp);
    end
  endtask

  task automatic check(input string name, input logic [2:0] stg, input logic all,
                       input logic [2:0] cause, input logic so);
    vectors++;
    cmp(name, "stage_h", bus_h.stage_reset_n, stg);
    cmp(name, "all_h",   {2'b00, bus_h.all_released}, {2'b00, all});
    cmp(name, "cause_h", bus_h.reset_cause, cause);
    cmp(name, "sync_h",  {2'b00, bus_h.sync_out}, {2'b00, so});
    cmp(name, "stage_l", bus_l.stage_reset_n, stg);
    cmp(name, "all_l",   {2'b00, bus_l.all_released}, {2'b00, all});
    cmp(name, "cause_l", bus_l.reset_cause, cause);
    cmp(name, "sync_l",  {2'b00, bus_l.sync_out}, {2'b00, so});
  endtask

  task automatic run_table();
    vec_t v;
    while (tbl.size() > 0) begin
      v = tbl.pop_front();
      drive(v.rst, v.lock, v.ext, v.sin, 1'b0);
      step(v.n);
      check($sformatf("row%0d", row_no), v.stg, v.all, v.cause, v.so);
      row_no++;
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start-up: reset, lock filter, stagger at e0+8/12/16, sync idle until stage 0
    add(3,  0, 0, 0, 0, 3'b000, 0, 3'b001, 1);
    add(13, 1, 1, 0, 0, 3'b000, 0, 3'b001, 1);
    add(1,  1, 1, 0, 0, 3'b001, 0, 3'b001, 1);
    add(3,  1, 1, 0, 0, 3'b001, 0, 3'b001, 0);
    add(1,  1, 1, 0, 0, 3'b011, 0, 3'b001, 0);
    add(3,  1, 1, 0, 0, 3'b011, 0, 3'b001, 0);
    add(1,  1, 1, 0, 0, 3'b111, 1, 3'b001, 0);
    run_table();

    // Synchroniser latency after release: two edges
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1); check("sync_rise_e1", 3'b111, 1'b1, 3'b001, 1'b0);
    step(1); check("sync_rise_e2", 3'b111, 1'b1, 3'b001, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1); check("sync_fall_e1", 3'b111, 1'b1, 3'b001, 1'b1);
    step(1); check("sync_fall_e2", 3'b111, 1'b1, 3'b001, 1'b0);

    // One-cycle lock loss, relock and full stagger
    add(1,  1, 0, 0, 0, 3'b111, 1, 3'b001, 0);
    add(1,  1, 1, 0, 0, 3'b111, 1, 3'b011, 0);
    add(1,  1, 1, 0, 0, 3'b000, 0, 3'b011, 0);
    add(11, 1, 1, 0, 0, 3'b000, 0, 3'b011, 1);
    add(1,  1, 1, 0, 0, 3'b001, 0, 3'b011, 1);
    add(3,  1, 1, 0, 0, 3'b001, 0, 3'b011, 0);
    add(1,  1, 1, 0, 0, 3'b011, 0, 3'b011, 0);
    add(3,  1, 1, 0, 0, 3'b011, 0, 3'b011, 0);
    add(1,  1, 1, 0, 0, 3'b111, 1, 3'b011, 0);
    // External reset for 10 cycles, then restart after synchronised deassert
    add(1,  1, 1, 1, 0, 3'b111, 1, 3'b011, 0);
    add(1,  1, 1, 1, 0, 3'b111, 1, 3'b111, 0);
    add(1,  1, 1, 1, 0, 3'b000, 0, 3'b111, 0);
    add(7,  1, 1, 1, 0, 3'b000, 0, 3'b111, 1);
    add(10, 1, 1, 0, 0, 3'b000, 0, 3'b111, 1);
    add(1,  1, 1, 0, 0, 3'b001, 0, 3'b111, 1);
    add(3,  1, 1, 0, 0, 3'b001, 0, 3'b111, 0);
    add(1,  1, 1, 0, 0, 3'b011, 0, 3'b111, 0);
    add(3,  1, 1, 0, 0, 3'b011, 0, 3'b111, 0);
    add(1,  1, 1, 0, 0, 3'b111, 1, 3'b111, 0);
    run_table();

    // Clear coinciding with lock-loss event, then clear alone
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1); check("lock_drop", 3'b111, 1'b1, 3'b111, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1); check("clr_vs_set", 3'b111, 1'b1, 3'b010, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1); check("lock_held", 3'b000, 1'b0, 3'b010, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1); check("clr_alone", 3'b000, 1'b0, 3'b000, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1); check("clr_after", 3'b000, 1'b0, 3'b000, 1'b1);

    // Master reset mid-sequence at count=5, then full restart
    step(6); check("count5", 3'b000, 1'b0, 3'b000, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1); check("mid_reset", 3'b000, 1'b0, 3'b001, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(3);  check("no_early_release", 3'b000, 1'b0, 3'b001, 1'b1);
    step(10); check("restart_hold", 3'b000, 1'b0, 3'b001, 1'b1);
    step(1);  check("restart_stage0", 3'b001, 1'b0, 3'b001, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
